// File: rtl/issue_scoreboard.sv
// Issue controller: tracks pending register writes in a busy scoreboard,
// stalls decoded instructions on RAW/WAW hazards and bounds the in-flight window.
module issue_scoreboard #(
  parameter int MAX_INFLIGHT = 4,
  parameter int CNT_W        = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  flush,
  input  logic                                  dec_valid,
  output logic                                  dec_ready,
  input  logic [4:0]                            dec_rs1,
  input  logic [4:0]                            dec_rs2,
  input  logic [4:0]                            dec_rd,
  output logic                                  iss_valid,
  input  logic                                  iss_ready,
  input  logic                                  wb_valid,
  input  logic [4:0]                            wb_rd,
  input  logic                                  retire,
  output logic [31:0]                           busy_mask,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0]     inflight,
  output logic                                  stall_raw,
  output logic                                  stall_full,
  output logic [CNT_W-1:0]                      stall_cycles
);

  localparam int IW = $clog2(MAX_INFLIGHT + 1);
  localparam logic [IW-1:0] MAX_CNT = IW'(MAX_INFLIGHT);
  localparam logic [IW-1:0] ONE_CNT = IW'(1);

  logic        wb_clr;
  logic [31:0] clr_vec;
  logic [31:0] set_vec;
  logic [31:0] eff_busy;
  logic [31:0] busy_next;
  logic        hazard;
  logic        full;
  logic        go;
  logic        fire;

  // A writeback landing this cycle releases its register for the hazard check
  // right away, so a dependent instruction can issue in the same cycle.
  always_comb begin
    wb_clr   = wb_valid & (wb_rd != 5'd0);
    clr_vec  = wb_clr ? (32'd1 << wb_rd) : 32'd0;
    eff_busy = busy_mask & ~clr_vec;
    hazard   = dec_valid & (eff_busy[dec_rs1] | eff_busy[dec_rs2] | eff_busy[dec_rd]);
    full     = (inflight == MAX_CNT);
    go       = ~hazard & ~full & ~flush & ~rst;
    iss_valid  = dec_valid & go;
    dec_ready  = iss_ready & go;
    fire       = iss_valid & iss_ready;
    stall_raw  = dec_valid & hazard & ~flush;
    stall_full = dec_valid & full & ~hazard & ~flush;
  end

  // Set from a new issue wins over a same-cycle clear of the same register.
  always_comb begin
    set_vec   = fire ? (32'd1 << dec_rd) : 32'd0;
    busy_next = ((busy_mask & ~clr_vec) | set_vec) & 32'hFFFF_FFFE;
    if (flush) busy_next = 32'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_mask <= 32'd0;
    end else begin
      busy_mask <= busy_next;
    end
  end

  // A retire only frees a slot on the following cycle; an illegal retire at zero holds.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      inflight <= '0;
    end else if (fire && !retire) begin
      inflight <= inflight + ONE_CNT;
    end else if (retire && !fire && inflight != '0) begin
      inflight <= inflight - ONE_CNT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if ((stall_raw || stall_full) && stall_cycles != '1) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

  a_no_retire_underflow : assert property (
    @(posedge clk) disable iff (rst)
    !(retire && !fire && inflight == '0)
  );

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed self-checking bench for issue_scoreboard (MAX_INFLIGHT=4, CNT_W=4 build).
module tb_issue_scoreboard;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        dec_valid;
  logic        dec_ready;
  logic [4:0]  dec_rs1;
  logic [4:0]  dec_rs2;
  logic [4:0]  dec_rd;
  logic        iss_valid;
  logic        iss_ready;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        retire;
  logic [31:0] busy_mask;
  logic [2:0]  inflight;
  logic        stall_raw;
  logic        stall_full;
  logic [3:0]  stall_cycles;

  int checkCount = 0;
  int failCount  = 0;

  issue_scoreboard #(.MAX_INFLIGHT(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .retire(retire),
    .busy_mask(busy_mask), .inflight(inflight),
    .stall_raw(stall_raw), .stall_full(stall_full),
    .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Inputs change just after a rising edge; #1 lets the combinational paths settle.
  task automatic applyStimulus(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input logic rdy, input logic wbv,
                               input logic [4:0] wbr, input logic ret, input logic fl);
    dec_valid = v;   dec_rs1 = rs1; dec_rs2 = rs2; dec_rd = rd;
    iss_ready = rdy; wb_valid = wbv; wb_rd = wbr; retire = ret; flush = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    checkOutput("rst_iss_valid", 32'(iss_valid), 32'd0);
    checkOutput("rst_dec_ready", 32'(dec_ready), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    idle();
    checkOutput("reset_busy", busy_mask, 32'd0);
    checkOutput("reset_inflight", 32'(inflight), 32'd0);
    checkOutput("reset_stalls", 32'(stall_cycles), 32'd0);

    // No-register instruction issues combinationally
    applyStimulus(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    checkOutput("idle_iss_valid", 32'(iss_valid), 32'd1);
    checkOutput("idle_dec_ready", 32'(dec_ready), 32'd1);
    tick();
    checkOutput("idle_inflight", 32'(inflight), 32'd1);
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0);
    tick();
    checkOutput("retire_inflight", 32'(inflight), 32'd0);

    // RAW on x5
    applyStimulus(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    checkOutput("raw_producer_fire", 32'(iss_valid), 32'd1);
    tick();
    checkOutput("raw_busy5", busy_mask, 32'h0000_0020);
    applyStimulus(1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    checkOutput("raw_stall_raw", 32'(stall_raw), 32'd1);
    checkOutput("raw_iss_valid", 32'(iss_valid), 32'd0);
    checkOutput("raw_dec_ready", 32'(dec_ready), 32'd0);
    tick();
    tick();
    checkOutput("raw_stall_count", 32'(stall_cycles), 32'd2);
    applyStimulus(1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0);
    checkOutput("raw_bypass_fire", 32'(iss_valid), 32'd1);
    checkOutput("raw_bypass_nostall", 32'(stall_raw), 32'd0);
    tick();
    checkOutput("raw_busy_after", busy_mask, 32'h0000_0040);
    checkOutput("raw_inflight", 32'(inflight), 32'd2);

    // WAW on x7, then set and clear of x7 in the same cycle
    applyStimulus(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    tick();
    checkOutput("waw_busy", busy_mask, 32'h0000_00C0);
    applyStimulus(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    checkOutput("waw_stall_raw", 32'(stall_raw), 32'd1);
    tick();
    applyStimulus(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0);
    checkOutput("waw_setclr_fire", 32'(iss_valid), 32'd1);
    tick();
    checkOutput("waw_setclr_busy", busy_mask, 32'h0000_00C0);
    checkOutput("full_inflight", 32'(inflight), 32'd4);
    checkOutput("waw_stall_count", 32'(stall_cycles), 32'd3);

    // Full window: retire during the stall frees a slot only next cycle
    applyStimulus(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0);
    checkOutput("full_stall_full", 32'(stall_full), 32'd1);
    checkOutput("full_stall_raw", 32'(stall_raw), 32'd0);
    checkOutput("full_iss_valid", 32'(iss_valid), 32'd0);
    tick();
    checkOutput("full_after_retire", 32'(inflight), 32'd3);
    checkOutput("full_stall_count", 32'(stall_cycles), 32'd4);
    applyStimulus(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0);
    checkOutput("fire_retire_iss", 32'(iss_valid), 32'd1);
    tick();
    checkOutput("fire_retire_hold", 32'(inflight), 32'd3);
    applyStimulus(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    tick();
    checkOutput("refill_inflight", 32'(inflight), 32'd4);

    // Build busy=0xA0, inflight=3 then flush with everything active
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0);
    tick();
    checkOutput("preflush_busy", busy_mask, 32'h0000_00A0);
    checkOutput("preflush_inflight", 32'(inflight), 32'd3);
    applyStimulus(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b1, 5'd7, 1'b1, 1'b1);
    checkOutput("flush_iss_valid", 32'(iss_valid), 32'd0);
    checkOutput("flush_dec_ready", 32'(dec_ready), 32'd0);
    checkOutput("flush_stall_raw", 32'(stall_raw), 32'd0);
    tick();
    checkOutput("flush_busy", busy_mask, 32'd0);
    checkOutput("flush_inflight", 32'(inflight), 32'd0);

    // Backpressure is not a counted stall
    applyStimulus(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    checkOutput("bp_dec_ready", 32'(dec_ready), 32'd0);
    checkOutput("bp_stall_full", 32'(stall_full), 32'd0);
    tick();
    tick();
    checkOutput("bp_stall_count", 32'(stall_cycles), 32'd4);
    checkOutput("bp_inflight", 32'(inflight), 32'd0);

    // Saturation: hold a RAW stall on x3 for 2^4+5 cycles
    applyStimulus(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 5'd0, 5'd3, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    for (int i = 0; i < 21; i++) tick();
    checkOutput("sat_stall_count", 32'(stall_cycles), 32'd15);
    checkOutput("sat_still_stalled", 32'(stall_raw), 32'd1);

    // Reset mid-operation discards tracking
    rst = 1'b1;
    idle();
    tick();
    rst = 1'b0;
    checkOutput("rerst_busy", busy_mask, 32'd0);
    checkOutput("rerst_inflight", 32'(inflight), 32'd0);
    checkOutput("rerst_stalls", 32'(stall_cycles), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
